// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback block.
// Contents:
//   reg_addr_t    5-bit architectural register address
//   wb_src_e      which producer owns the write port in a given cycle
//   STARVE_CNT_W  width of the long-channel starvation counter
package tiny5_wb_pkg;
  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_LONG
  } wb_src_e;

  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/regfile_writeback_if.sv
// Result-channel bundle between the two producers and the writeback block.
// Signals:
//   pipe_valid/pipe_rd/pipe_data  single-cycle pipe result (no back-pressure)
//   long_valid/long_rd/long_data  multi-cycle result, handshaked by long_ready
//   long_ready                    writeback accepts the long result this cycle
// Modports: master = producers, slave = writeback block.
interface regfile_writeback_if #(
  parameter int XLEN = 32
);
  import tiny5_wb_pkg::*;

  logic            pipe_valid;
  reg_addr_t       pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            long_valid;
  reg_addr_t       long_rd;
  logic [XLEN-1:0] long_data;
  logic            long_ready;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output long_valid, long_rd, long_data,
    input  long_ready
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  long_valid, long_rd, long_data,
    output long_ready
  );
endinterface

// File: rtl/regfile_writeback_scoreboard.sv
// Pending-destination scoreboard for registers owed by the long channel.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   set_en_i/set_rd_i   a long op issues and will write set_rd_i
//   clr_en_i/clr_rd_i   a long result is accepted for clr_rd_i
//   lk_*_i / busy_*_o   three combinational lookups; address 0 is never busy
module wb_scoreboard
  import tiny5_wb_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      set_en_i,
  input  reg_addr_t set_rd_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_rd_i,
  input  reg_addr_t lk_a_i,
  input  reg_addr_t lk_b_i,
  input  reg_addr_t lk_c_i,
  output logic      busy_a_o,
  output logic      busy_b_o,
  output logic      busy_c_o
);
  logic [31:1] r_pending;
  logic [31:1] w_pending_nxt;
  logic [31:0] w_pending_full;

  // Clear is applied first so that a same-cycle issue to the same register
  // re-arms the bit: the new op supersedes the result being retired.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 1; i < 32; i++) begin
      if (clr_en_i && clr_rd_i == reg_addr_t'(i)) w_pending_nxt[i] = 1'b0;
      if (set_en_i && set_rd_i == reg_addr_t'(i)) w_pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_pending <= '0;
    else         r_pending <= w_pending_nxt;
  end

  // Bit 0 tied low so x0 lookups always read as free.
  assign w_pending_full = {r_pending, 1'b0};
  assign busy_a_o = w_pending_full[lk_a_i];
  assign busy_b_o = w_pending_full[lk_b_i];
  assign busy_c_o = w_pending_full[lk_c_i];
endmodule

// File: rtl/regfile_writeback.sv
// Writer side of the 31x32 register file. Merges the single-cycle pipe
// channel and the handshaked long channel onto one registered write port,
// tracks registers still owed by the long channel, and raises a pipe stall
// when the long channel has waited STARVE_MAX consecutive cycles.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   wb (slave)                      pipe/long result channels, long_ready
//   issue_valid_i, issue_rd_i       long op issue (sets scoreboard bit)
//   chk_rs1/rs2/rd_i, busy_*_o      decode hazard lookups
//   pipe_stall_o                    upstream must hold pipe_valid low
//   rf_wr_en/addr/data_o            registered register-file write port
// Optional (macro TINY5_WB_BYPASS_EN):
//   rf_rd_data1/2_i, fwd_rs1/2_data_o  forwarding across the write-then-read gap
module regfile_writeback
  import tiny5_wb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  regfile_writeback_if.slave wb,
  input  logic             issue_valid_i,
  input  reg_addr_t        issue_rd_i,
  input  reg_addr_t        chk_rs1_i,
  input  reg_addr_t        chk_rs2_i,
  input  reg_addr_t        chk_rd_i,
  output logic             busy_rs1_o,
  output logic             busy_rs2_o,
  output logic             busy_rd_o,
  output logic             pipe_stall_o,
  output logic             rf_wr_en_o,
  output reg_addr_t        rf_wr_addr_o,
  output logic [XLEN-1:0]  rf_wr_data_o
`ifdef TINY5_WB_BYPASS_EN
  ,
  input  logic [XLEN-1:0]  rf_rd_data1_i,
  input  logic [XLEN-1:0]  rf_rd_data2_i,
  output logic [XLEN-1:0]  fwd_rs1_data_o,
  output logic [XLEN-1:0]  fwd_rs2_data_o
`endif
);
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  wb_src_e                 w_sel;
  logic                    w_long_ready;
  logic                    w_long_hs;
  reg_addr_t               w_sel_rd;
  logic [XLEN-1:0]         w_sel_data;
  logic [STARVE_CNT_W-1:0] w_cnt_inc;

  logic                    r_stall;
  logic [STARVE_CNT_W-1:0] r_cnt;
  logic                    r_wr_en;
  reg_addr_t               r_wr_addr;
  logic [XLEN-1:0]         r_wr_data;

  // Pipe wins unless stalled; a pipe result arriving during a stall is
  // dropped in favour of the long channel.
  always_comb begin
    w_sel        = WB_NONE;
    w_long_ready = 1'b0;
    w_sel_rd     = '0;
    w_sel_data   = '0;
    if (!r_stall && wb.pipe_valid) begin
      w_sel      = WB_PIPE;
      w_sel_rd   = wb.pipe_rd;
      w_sel_data = wb.pipe_data;
    end else if (wb.long_valid) begin
      w_sel        = WB_LONG;
      w_long_ready = 1'b1;
      w_sel_rd     = wb.long_rd;
      w_sel_data   = wb.long_data;
    end
  end

  assign wb.long_ready = w_long_ready;
  assign w_long_hs     = wb.long_valid & w_long_ready;
  assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cnt     <= '0;
      r_stall   <= 1'b0;
    end else begin
      r_wr_en   <= (w_sel != WB_NONE) && (w_sel_rd != '0);
      r_wr_addr <= w_sel_rd;
      r_wr_data <= w_sel_data;
      // Counter and stall only live while the long channel is waiting.
      if (w_long_hs || !wb.long_valid) begin
        r_cnt   <= '0;
        r_stall <= 1'b0;
      end else begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc >= STARVE_LIM) r_stall <= 1'b1;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .set_en_i (issue_valid_i && issue_rd_i != '0),
    .set_rd_i (issue_rd_i),
    .clr_en_i (w_long_hs),
    .clr_rd_i (wb.long_rd),
    .lk_a_i   (chk_rs1_i),
    .lk_b_i   (chk_rs2_i),
    .lk_c_i   (chk_rd_i),
    .busy_a_o (busy_rs1_o),
    .busy_b_o (busy_rs2_o),
    .busy_c_o (busy_rd_o)
  );

  assign pipe_stall_o = r_stall;
  assign rf_wr_en_o   = r_wr_en;
  assign rf_wr_addr_o = r_wr_addr;
  assign rf_wr_data_o = r_wr_data;

`ifdef TINY5_WB_BYPASS_EN
  // The register file has no write-through, so the value being written this
  // cycle is forwarded to a same-cycle read of that register.
  assign fwd_rs1_data_o = (r_wr_en && r_wr_addr == chk_rs1_i && chk_rs1_i != '0)
                          ? r_wr_data : rf_rd_data1_i;
  assign fwd_rs2_data_o = (r_wr_en && r_wr_addr == chk_rs2_i && chk_rs2_i != '0)
                          ? r_wr_data : rf_rd_data2_i;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        busy_rs1, busy_rs2, busy_rd;
  logic        pipe_stall;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
`ifdef TINY5_WB_BYPASS_EN
  logic [31:0] rf_rd_data1, rf_rd_data2, fwd_rs1, fwd_rs2;
`endif

  int errors = 0;
  int checks = 0;

  regfile_writeback_if #(.XLEN(32)) wb ();

  regfile_writeback #(.STARVE_MAX(4), .XLEN(32)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .wb            (wb),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .chk_rs1_i     (chk_rs1),
    .chk_rs2_i     (chk_rs2),
    .chk_rd_i      (chk_rd),
    .busy_rs1_o    (busy_rs1),
    .busy_rs2_o    (busy_rs2),
    .busy_rd_o     (busy_rd),
    .pipe_stall_o  (pipe_stall),
    .rf_wr_en_o    (rf_wr_en),
    .rf_wr_addr_o  (rf_wr_addr),
    .rf_wr_data_o  (rf_wr_data)
`ifdef TINY5_WB_BYPASS_EN
    ,
    .rf_rd_data1_i (rf_rd_data1),
    .rf_rd_data2_i (rf_rd_data2),
    .fwd_rs1_data_o(fwd_rs1),
    .fwd_rs2_data_o(fwd_rs2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.pipe_valid = 1'b0; wb.pipe_rd = '0; wb.pipe_data = '0;
    wb.long_valid = 1'b0; wb.long_rd = '0; wb.long_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
`ifdef TINY5_WB_BYPASS_EN
    rf_rd_data1 = '0; rf_rd_data2 = '0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", rf_wr_en); end
    checks++; if (rf_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", rf_wr_data); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", pipe_stall); end
    checks++; if (wb.long_ready !== 1'b0) begin errors++; $display("FAIL reset_long_ready got=%0b exp=0", wb.long_ready); end
    chk_rs1 = 5'd9; chk_rs2 = 5'd31; chk_rd = 5'd1; #1;
    checks++; if ({busy_rs1, busy_rs2, busy_rd} !== 3'b000) begin errors++; $display("FAIL reset_busy got=%b exp=000", {busy_rs1, busy_rs2, busy_rd}); end
    idle_inputs();
  endtask

  task automatic test_pipe_write();
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd5; wb.pipe_data = 32'hDEADBEEF;
    step();
    wb.pipe_valid = 1'b0;
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL pipe_wr_en got=%0b exp=1", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd5) begin errors++; $display("FAIL pipe_wr_addr got=%0d exp=5", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wr_data got=%h exp=deadbeef", rf_wr_data); end
    step();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL pipe_wr_en_idle got=%0b exp=0", rf_wr_en); end
  endtask

  task automatic test_arbitration();
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h0000_0333;
    wb.long_valid = 1'b1; wb.long_rd = 5'd7; wb.long_data = 32'h0000_0777;
    #1;
    checks++; if (wb.long_ready !== 1'b0) begin errors++; $display("FAIL arb_ready_blocked got=%0b exp=0", wb.long_ready); end
    step();
    wb.pipe_valid = 1'b0;
    #1;
    checks++; if (wb.long_ready !== 1'b1) begin errors++; $display("FAIL arb_ready_free got=%0b exp=1", wb.long_ready); end
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'h333) begin
      errors++; $display("FAIL arb_pipe_write got=%0b/%0d/%h exp=1/3/00000333", rf_wr_en, rf_wr_addr, rf_wr_data); end
    step();
    wb.long_valid = 1'b0;
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h777) begin
      errors++; $display("FAIL arb_long_write got=%0b/%0d/%h exp=1/7/00000777", rf_wr_en, rf_wr_addr, rf_wr_data); end
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    chk_rs1 = 5'd9; chk_rs2 = 5'd8; chk_rd = 5'd9;
    #1;
    checks++; if ({busy_rs1, busy_rs2, busy_rd} !== 3'b101) begin errors++; $display("FAIL sb_set got=%b exp=101", {busy_rs1, busy_rs2, busy_rd}); end
    wb.long_valid = 1'b1; wb.long_rd = 5'd9; wb.long_data = 32'h99;
    step();
    wb.long_valid = 1'b0;
    #1;
    checks++; if (busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_clear got=%0b exp=0", busy_rs1); end
    // Re-arm, then issue and retire r9 in the same cycle: issue wins.
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    wb.long_valid = 1'b1; wb.long_rd = 5'd9;
    step();
    issue_valid = 1'b0; wb.long_valid = 1'b0;
    #1;
    checks++; if (busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%0b exp=1", busy_rs1); end
    // Retire the remaining r9.
    wb.long_valid = 1'b1;
    step();
    wb.long_valid = 1'b0;
    #1;
    checks++; if (busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_final_clear got=%0b exp=0", busy_rs1); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd12; wb.pipe_data = 32'hC0;
    wb.long_valid = 1'b1; wb.long_rd = 5'd11; wb.long_data = 32'hB0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_early_%0d got=%0b exp=0", i, pipe_stall); end
    end
    step();
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_raise got=%0b exp=1", pipe_stall); end
    checks++; if (rf_wr_addr !== 5'd12) begin errors++; $display("FAIL starve_pipe_addr got=%0d exp=12", rf_wr_addr); end
    wb.pipe_valid = 1'b0;
    #1;
    checks++; if (wb.long_ready !== 1'b1) begin errors++; $display("FAIL starve_long_ready got=%0b exp=1", wb.long_ready); end
    step();
    wb.long_valid = 1'b0;
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_drop got=%0b exp=0", pipe_stall); end
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd11 || rf_wr_data !== 32'hB0) begin
      errors++; $display("FAIL starve_long_write got=%0b/%0d/%h exp=1/11/000000b0", rf_wr_en, rf_wr_addr, rf_wr_data); end
    step();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd0; wb.pipe_data = 32'h1234;
    step();
    wb.pipe_valid = 1'b0;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rd0_wr_en got=%0b exp=0", rf_wr_en); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    issue_valid = 1'b0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    #1;
    checks++; if ({busy_rs1, busy_rs2, busy_rd} !== 3'b000) begin errors++; $display("FAIL rd0_busy got=%b exp=000", {busy_rs1, busy_rs2, busy_rd}); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd13;
    wb.long_valid = 1'b1; wb.long_rd = 5'd20; wb.long_data = 32'h20;
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd14; wb.pipe_data = 32'h14;
    step(); step();
    issue_valid = 1'b0;
    wb.pipe_rd = 5'd15;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    chk_rd = 5'd13;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got=%0b exp=0", rf_wr_en); end
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy_rd); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%0b exp=0", pipe_stall); end
    idle_inputs();
  endtask

`ifdef TINY5_WB_BYPASS_EN
  task automatic test_bypass();
    wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd4; wb.pipe_data = 32'hA5A5A5A5;
    step();
    wb.pipe_valid = 1'b0;
    chk_rs2 = 5'd4; rf_rd_data2 = 32'h0;
    chk_rs1 = 5'd5; rf_rd_data1 = 32'h11;
    #1;
    checks++; if (fwd_rs2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_rs2 got=%h exp=a5a5a5a5", fwd_rs2); end
    checks++; if (fwd_rs1 !== 32'h11) begin errors++; $display("FAIL bypass_rs1 got=%h exp=00000011", fwd_rs1); end
    step();
    idle_inputs();
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe_write();
    test_arbitration();
    test_scoreboard();
    test_starvation();
    test_rd_zero();
    test_reset_mid();
`ifdef TINY5_WB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
